// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// drives the IF/ID register, honouring decode stalls and jump redirects.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] BUBBLE_IR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump,
  input  logic [15:0] new_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] pc_out,
  output logic [15:0] ir_out,
  output logic [15:0] PCP2,
  output logic        valid_out
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] buf_ir;
  logic [15:0] redir_pc;
  logic        redir_pend;
  logic [15:0] jump_pc;
  logic [15:0] pc_inc;

  assign jump_pc   = {new_pc[15:1], 1'b0};
  assign pc_inc    = pc + 16'd2;
  assign imem_addr = pc;

  // NOTE: all state below uses non-blocking assignments so every branch sees
  // the pre-edge values of pc, state and redir_pend, whatever the order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      imem_req   <= 1'b0;
      pc         <= RESET_PC;
      pc_out     <= 16'h0000;
      ir_out     <= BUBBLE_IR;
      PCP2       <= 16'h0000;
      valid_out  <= 1'b0;
      redir_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            if (jump || redir_pend) begin
              // The returning word belongs to the abandoned path.
              pc         <= jump ? jump_pc : redir_pc;
              redir_pend <= 1'b0;
              valid_out  <= 1'b0;
              ir_out     <= BUBBLE_IR;
            end else if (!stall) begin
              pc_out    <= pc;
              ir_out    <= imem_data;
              PCP2      <= pc_inc;
              valid_out <= 1'b1;
              pc        <= pc_inc;
            end else begin
              state    <= HOLD;
              imem_req <= 1'b0;
            end
          end else if (jump) begin
            // Request address must stay stable, so the target is parked.
            redir_pend <= 1'b1;
            valid_out  <= 1'b0;
            ir_out     <= BUBBLE_IR;
          end else if (!stall) begin
            valid_out <= 1'b0;
            ir_out    <= BUBBLE_IR;
          end
        end
        HOLD: begin
          if (jump) begin
            pc        <= jump_pc;
            valid_out <= 1'b0;
            ir_out    <= BUBBLE_IR;
            state     <= FETCH;
            imem_req  <= 1'b1;
          end else if (!stall) begin
            pc_out    <= pc;
            ir_out    <= buf_ir;
            PCP2      <= pc_inc;
            valid_out <= 1'b1;
            pc        <= pc_inc;
            state     <= FETCH;
            imem_req  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: buf_ir and redir_pc carry no reset; they are only read while
  // qualified by HOLD or redir_pend, both of which reset clears.
  always_ff @(posedge clk) begin
    if (state == FETCH && imem_ack && !jump && !redir_pend && stall)
      buf_ir <= imem_data;
    if (state == FETCH && !imem_ack && jump)
      redir_pc <= jump_pc;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scoreboard of IF/ID loads plus
// per-scenario inline checks against a latency-programmable memory model.
module tb_fetch_stage;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] pcp2;
  } ifid_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, jump;
  logic [15:0] new_pc;
  logic        imem_req, imem_ack, valid_out;
  logic [15:0] imem_addr, imem_data, pc_out, ir_out, PCP2;

  logic        w_stall = 1'b0, w_jump = 1'b0;
  logic [15:0] w_new_pc = 16'h0000;
  logic        w_req, w_ack, w_valid;
  logic [15:0] w_addr, w_data, w_pc_out, w_ir, w_pcp2;

  int    lat = 1;
  int    wait_cnt;
  int    errors = 0;
  int    checks = 0;
  logic  st_q, rst_q;
  ifid_t exp_q[$];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump), .new_pc(new_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .pc_out(pc_out), .ir_out(ir_out), .PCP2(PCP2),
    .valid_out(valid_out)
  );

  fetch_stage #(.RESET_PC(16'hFFFE), .BUBBLE_IR(16'h0000)) u_wrap (
    .clk(clk), .reset(reset), .stall(w_stall), .jump(w_jump), .new_pc(w_new_pc),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
    .imem_data(w_data), .pc_out(w_pc_out), .ir_out(w_ir), .PCP2(w_pcp2),
    .valid_out(w_valid)
  );

  // Memory model: ack after lat cycles of a held request (lat=1 is zero-wait).
  always @(posedge clk or negedge reset) begin
    if (!reset)                     wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                            wait_cnt <= 0;
  end
  assign imem_ack  = imem_req && (wait_cnt >= lat - 1);
  assign imem_data = imem_addr ^ 16'hA5A5;
  assign w_ack     = w_req;
  assign w_data    = w_addr ^ 16'hA5A5;

  // A new IF/ID load is any edge taken out of reset with stall low that
  // leaves valid_out high; each must match the next expected entry.
  always @(posedge clk) begin
    st_q  <= stall;
    rst_q <= reset;
  end

  always @(negedge clk) begin
    if (rst_q && reset && !st_q && valid_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got {%h,%h,%h}, required no load", pc_out, ir_out, PCP2);
      end else begin
        ifid_t e;
        e = exp_q.pop_front();
        if ({pc_out, ir_out, PCP2} !== e) begin
          errors++;
          $display("FAIL sb_ifid: got {%h,%h,%h}, required {%h,%h,%h}",
                   pc_out, ir_out, PCP2, e.pc, e.ir, e.pcp2);
        end
      end
    end
  end

  function automatic ifid_t exp_of(input logic [15:0] a);
    ifid_t e;
    e.pc   = a;
    e.ir   = a ^ 16'hA5A5;
    e.pcp2 = a + 16'd2;
    return e;
  endfunction

  task automatic test_reset;
    reset = 1'b0; stall = 1'b0; jump = 1'b0; new_pc = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({imem_req, valid_out, pc_out, ir_out, PCP2, imem_addr} !==
        {1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL reset_state: got req=%b v=%b pc_out=%h ir=%h pcp2=%h addr=%h, required 0 0 0000 0000 0000 0000",
               imem_req, valid_out, pc_out, ir_out, PCP2, imem_addr);
    end
    checks++;
    if ({w_req, w_addr} !== {1'b0, 16'hFFFE}) begin
      errors++;
      $display("FAIL reset_wrap: got req=%b addr=%h, required 0 fffe", w_req, w_addr);
    end
  endtask

  task automatic test_streaming;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL idle_req: got %b, required 0", imem_req);
    end
    exp_q.push_back(exp_of(16'h0000));
    exp_q.push_back(exp_of(16'h0002));
    @(posedge clk); @(negedge clk);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      errors++; $display("FAIL stream_addr0: got req=%b addr=%h, required 1 0000", imem_req, imem_addr);
    end
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({valid_out, imem_addr} !== {1'b1, 16'(2 * i)}) begin
        errors++;
        $display("FAIL stream_step%0d: got v=%b addr=%h, required 1 %h", i, valid_out, imem_addr, 16'(2 * i));
      end
    end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({imem_req, valid_out, pc_out} !== {1'b0, 1'b1, 16'h0002}) begin
        errors++;
        $display("FAIL stall_hold%0d: got req=%b v=%b pc_out=%h, required 0 1 0002", i, imem_req, valid_out, pc_out);
      end
    end
    stall = 1'b0;
    exp_q.push_back(exp_of(16'h0004));
    exp_q.push_back(exp_of(16'h0006));
    @(posedge clk); @(negedge clk);
    checks++;
    if ({imem_req, imem_addr, ir_out} !== {1'b1, 16'h0006, 16'hA5A1}) begin
      errors++;
      $display("FAIL stall_release: got req=%b addr=%h ir=%h, required 1 0006 a5a1", imem_req, imem_addr, ir_out);
    end
    @(posedge clk); @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0 || imem_addr !== 16'h0008) begin
      errors++;
      $display("FAIL stall_drain: got pending=%0d addr=%h, required 0 0008", exp_q.size(), imem_addr);
    end
  endtask

  task automatic test_jump_zero_wait;
    jump = 1'b1; new_pc = 16'h0101;
    @(posedge clk); @(negedge clk);
    jump = 1'b0;
    checks++;
    if ({imem_addr, valid_out, ir_out, pc_out, PCP2} !==
        {16'h0100, 1'b0, 16'h0000, 16'h0006, 16'h0008}) begin
      errors++;
      $display("FAIL jump_flush: got addr=%h v=%b ir=%h pc_out=%h pcp2=%h, required 0100 0 0000 0006 0008",
               imem_addr, valid_out, ir_out, pc_out, PCP2);
    end
    exp_q.push_back(exp_of(16'h0100));
    @(posedge clk); @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0 || imem_addr !== 16'h0102) begin
      errors++;
      $display("FAIL jump_target: got pending=%0d addr=%h, required 0 0102", exp_q.size(), imem_addr);
    end
  endtask

  task automatic test_jump_during_wait;
    lat = 3;
    #1;
    jump = 1'b1; new_pc = 16'h0200;
    @(posedge clk); @(negedge clk);
    jump = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({imem_req, imem_addr, valid_out} !== {1'b1, 16'h0102, 1'b0}) begin
        errors++;
        $display("FAIL wait_addr%0d: got req=%b addr=%h v=%b, required 1 0102 0", i, imem_req, imem_addr, valid_out);
      end
      if (i == 0) begin @(posedge clk); @(negedge clk); end
    end
    checks++;
    if (imem_ack !== 1'b1) begin
      errors++; $display("FAIL wait_ack: got %b, required 1", imem_ack);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if ({imem_req, imem_addr, valid_out} !== {1'b1, 16'h0200, 1'b0}) begin
      errors++;
      $display("FAIL wait_redirect: got req=%b addr=%h v=%b, required 1 0200 0", imem_req, imem_addr, valid_out);
    end
    exp_q.push_back(exp_of(16'h0200));
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0 || imem_addr !== 16'h0202 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL wait_deliver: got pending=%0d addr=%h v=%b, required 0 0202 1", exp_q.size(), imem_addr, valid_out);
    end
  endtask

  task automatic test_reset_mid_hold;
    lat = 1;
    stall = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({imem_req, valid_out} !== {1'b0, 1'b1}) begin
      errors++; $display("FAIL hold_entry: got req=%b v=%b, required 0 1", imem_req, valid_out);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({imem_req, valid_out, pc_out, ir_out, PCP2, imem_addr} !==
        {1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL async_reset: got req=%b v=%b pc_out=%h ir=%h pcp2=%h addr=%h, required 0 0 0000 0000 0000 0000",
               imem_req, valid_out, pc_out, ir_out, PCP2, imem_addr);
    end
    @(posedge clk); #1;
    reset = 1'b1; stall = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL restart_idle: got req=%b, required 0", imem_req);
    end
    exp_q.push_back(exp_of(16'h0000));
    @(posedge clk); @(negedge clk);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      errors++; $display("FAIL restart_addr: got req=%b addr=%h, required 1 0000", imem_req, imem_addr);
    end
    @(posedge clk); @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL restart_load: got pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_wrap;
    stall = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    @(posedge clk); @(negedge clk);
    checks++;
    if ({w_req, w_addr} !== {1'b1, 16'hFFFE}) begin
      errors++; $display("FAIL wrap_req: got req=%b addr=%h, required 1 fffe", w_req, w_addr);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if ({w_valid, w_pc_out, w_ir, w_pcp2, w_addr} !==
        {1'b1, 16'hFFFE, 16'h5A5B, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_ifid: got v=%b {%h,%h,%h} addr=%h, required 1 {fffe,5a5b,0000} 0000",
               w_valid, w_pc_out, w_ir, w_pcp2, w_addr);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_jump_zero_wait();
    test_jump_during_wait();
    test_reset_mid_hold();
    test_wrap();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got pending=%0d, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit MISC-V pipeline, directly upstream of the decode stage. Owns the program counter and issues requests to instruction memory over a variable-latency req/ack handshake. Drives the IF/ID pipeline register (`pc_out`, `ir_out`, `PCP2`), which decode consumes as `pc_in`, `ir_in`, `IPCP2`. Accepts stall and jump-redirect (`jump`, `new_pc`) from decode.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `BUBBLE_IR`, default 16'h0000: NOP encoding driven on `ir_out` for bubbles and flushes.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  decode cannot accept; IF/ID register holds.
- `jump`  in  1  redirect request from decode.
- `new_pc`  in  16  redirect target; bit 0 forced to 0.
- `imem_req`  out  1  instruction memory request.
- `imem_addr`  out  16  fetch address (equals PC).
- `imem_ack`  in  1  data valid on `imem_data` this cycle.
- `imem_data`  in  16  instruction word.
- `pc_out`  out  16  PC of the instruction in IF/ID.
- `ir_out`  out  16  instruction in IF/ID.
- `PCP2`  out  16  `pc_out` + 2.
- `valid_out`  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- State: `pc`; FSM {IDLE, FETCH, HOLD}; `buf` (16-bit held instruction); `redir_pend` flag plus `redir_pc`.
- Reset values: FSM=IDLE, `pc`=RESET_PC, `pc_out`=0, `ir_out`=BUBBLE_IR, `PCP2`=0, `valid_out`=0, `redir_pend`=0, `imem_req`=0.
- IDLE: `imem_req`=0. Moves to FETCH unconditionally on the next edge.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. Both stay stable until `imem_ack`. Evaluation on an ack cycle, in priority order:
  - `jump` or `redir_pend`: discard data; `pc` <= target (`new_pc` if `jump`, else `redir_pc`); clear `redir_pend`; flush IF/ID.
  - `stall`=0: IF/ID <= {`pc`, `imem_data`, `pc`+2}, `valid_out` <= 1; `pc` <= `pc`+2.
  - `stall`=1: `buf` <= `imem_data`; go to HOLD; IF/ID unchanged.
- FETCH with no ack:
  - `jump`: `redir_pend` <= 1, `redir_pc` <= `new_pc` (the latest jump wins); flush IF/ID.
  - else if `stall`=0: IF/ID <= bubble.
  - else IF/ID holds.
- HOLD: `imem_req`=0.
  - `jump`: drop `buf`; `pc` <= `new_pc`; flush; go to FETCH.
  - else if `stall`=0: IF/ID <= {`pc`, `buf`, `pc`+2}, `valid_out` <= 1; `pc` <= `pc`+2; go to FETCH.
  - else remain in HOLD.
- Flush and bubble both mean `valid_out`=0 and `ir_out`=BUBBLE_IR; `pc_out` and `PCP2` keep their values.
- `jump` takes priority over `stall` in every state.
- Arithmetic: all PC sums are modulo 2^16. 16'hFFFE + 2 = 16'h0000.

## Timing
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle. IF/ID loads on the edge that ends the ack cycle.
- First request: the cycle after the first edge following reset release (one IDLE cycle).
- Memory latency N cycles: N-1 bubble cycles precede each instruction when unstalled.
- Redirect: first request to the target is issued the cycle after `jump` (or after the ack of an in-flight request). Jump-to-IF/ID-valid takes at least 2 cycles.
- Stalled instructions are delivered exactly once: no skip, no duplicate.
- Reset assertion at any time, mid-handshake included, forces reset values immediately without a clock. An in-flight memory response is ignored.

## Test plan
- **Streaming:** RESET_PC=0, ack tied to 1, `imem_data`=addr^16'hA5A5. Required: `imem_addr` 0000, 0002, 0004. IF/ID shows {0000, A5A5, 0002}, then {0002, A5A7, 0004}, with `valid_out`=1 every cycle after the first fetch.
- **Stall:** assert `stall` for 3 cycles while the instruction at 0004 is acked. Required: IF/ID holds pc 0002; `imem_req`=0 in HOLD. After release, IF/ID = {0004, A5A1, 0006}, then 0006 follows.
- **Jump with zero-wait memory:** `jump`=1, `new_pc`=16'h0101. Required: next `imem_addr`=0100; IF/ID flushed (`valid_out`=0, `ir_out`=0000) for one cycle, then {0100, A4A5, 0102}.
- **Jump during a wait:** ack latency 3, `jump` pulsed to 0200 during the first wait cycle. Required: `imem_addr` stays at the old PC until ack; that data is discarded; the next request goes to 0200.
- **Wrap-around:** RESET_PC=16'hFFFE. Required: IF/ID {FFFE, 5A5B, 0000}; next `imem_addr`=0000.
- **Reset mid-HOLD:** drive `reset` low asynchronously between edges while in HOLD. Required: outputs return to reset values before the next edge; fetch restarts at RESET_PC after reset release plus one IDLE cycle.
